// File: rtl/eth_pcs_pkg.sv
// -----------------------------------------------------------------------------
// eth_pcs_pkg
// Shared constants and types for the 10GBASE-R PCS datapath blocks.
//   W_DATA             PMA word width and width of each emitted payload half
//   W_SYNC             sync header width
//   W_TRANS_PER_BLK    width of the payload-half index (two halves per block)
//   W_RX_GEARBOX_BUF   receive gearbox buffer width (header + three words)
//   W_RX_GEARBOX_FILL  width of the receive gearbox fill counter (0..97)
//   SYNC_DATA/CTRL     legal sync header values, bit 0 received first
// -----------------------------------------------------------------------------
package eth_pcs_pkg;

   localparam int unsigned W_DATA            = 32;
   localparam int unsigned W_SYNC            = 2;
   localparam int unsigned W_TRANS_PER_BLK   = 1;
   localparam int unsigned W_RX_GEARBOX_BUF  = W_SYNC + 3 * W_DATA;
   localparam int unsigned W_RX_GEARBOX_FILL = 7;

   localparam logic [W_SYNC-1:0] SYNC_DATA = 2'b01;
   localparam logic [W_SYNC-1:0] SYNC_CTRL = 2'b10;

   // What the receive gearbox does on a given edge, in priority order.
   typedef enum logic [1:0] {
      ActIdle,
      ActSlip,
      ActHalf0,
      ActHalf1
   } rx_gb_action_e;

endpackage

// File: rtl/eth_pcs_rx_gearbox.sv
// -----------------------------------------------------------------------------
// eth_pcs_rx_gearbox
// Receive-side 32-to-66 gearbox. Accumulates one PMA word per cycle into a bit
// buffer (bit 0 oldest) and emits each 66-bit block as a sync header plus two
// 32-bit halves. A single-bit slip, requested by the block-lock FSM, is held
// until the next block boundary and then discards one bit to move alignment.
//
// Ports:
//   i_clk        clock
//   i_reset      synchronous, active-high reset
//   i_pma_data   PMA word, bit 0 earliest, valid every cycle
//   i_slip       one-cycle request to drop one bit at the next block boundary
//   o_valid      o_rx_data / o_sync_data carry a transfer this cycle
//   o_sync_data  block sync header (meaningful with o_valid and o_trans_cnt=0)
//   o_rx_data    payload half, half 0 first then half 1
//   o_trans_cnt  payload half index of the current output
//   o_slip_done  one-cycle pulse in the cycle the slip is executed
// -----------------------------------------------------------------------------
module eth_pcs_rx_gearbox
   import eth_pcs_pkg::*;
(
   input  logic                       i_clk,
   input  logic                       i_reset,
   input  logic [W_DATA-1:0]          i_pma_data,
   input  logic                       i_slip,
   output logic                       o_valid,
   output logic [W_SYNC-1:0]          o_sync_data,
   output logic [W_DATA-1:0]          o_rx_data,
   output logic [W_TRANS_PER_BLK-1:0] o_trans_cnt,
   output logic                       o_slip_done
);

   localparam logic [W_RX_GEARBOX_FILL-1:0] FILL_ONE  = W_RX_GEARBOX_FILL'(1);
   localparam logic [W_RX_GEARBOX_FILL-1:0] FILL_WORD = W_RX_GEARBOX_FILL'(W_DATA);
   localparam logic [W_RX_GEARBOX_FILL-1:0] FILL_HEAD = W_RX_GEARBOX_FILL'(W_SYNC + W_DATA);

   localparam logic [W_TRANS_PER_BLK-1:0] TCNT_HALF0 = '0;
   localparam logic [W_TRANS_PER_BLK-1:0] TCNT_HALF1 = W_TRANS_PER_BLK'(1);

   // Buffer state
   logic [W_RX_GEARBOX_BUF-1:0]  q_buf, d_buf;
   logic [W_RX_GEARBOX_FILL-1:0] q_fill, d_fill;
   logic [W_TRANS_PER_BLK-1:0]   q_tcnt, d_tcnt;
   logic                         q_slip_pend, d_slip_pend;

   // Next values of the registered outputs
   logic                       d_valid;
   logic [W_SYNC-1:0]          d_sync;
   logic [W_DATA-1:0]          d_rx;
   logic [W_TRANS_PER_BLK-1:0] d_trans_cnt;
   logic                       d_slip_done;

   rx_gb_action_e                action;
   logic                         slip_req;
   logic [W_RX_GEARBOX_FILL-1:0] consumed;
   logic [W_RX_GEARBOX_FILL-1:0] insert_pos;

   // Decide this edge's action from the pre-append buffer only.
   always_comb begin
      slip_req = q_slip_pend | i_slip;
      action   = ActIdle;
      if (q_tcnt == TCNT_HALF0 && slip_req && q_fill >= FILL_ONE) begin
         action = ActSlip;
      end else if (q_tcnt == TCNT_HALF0 && q_fill >= FILL_HEAD) begin
         action = ActHalf0;
      end else if (q_tcnt == TCNT_HALF1 && q_fill >= FILL_WORD) begin
         action = ActHalf1;
      end
   end

   always_comb begin
      consumed    = '0;
      d_tcnt      = q_tcnt;
      d_valid     = 1'b0;
      d_slip_done = 1'b0;
      d_sync      = o_sync_data;
      d_rx        = o_rx_data;
      d_trans_cnt = o_trans_cnt;

      unique case (action)
         ActSlip: begin
            consumed    = FILL_ONE;
            d_slip_done = 1'b1;
         end
         ActHalf0: begin
            consumed    = FILL_HEAD;
            d_sync      = q_buf[W_SYNC-1:0];
            d_rx        = q_buf[W_SYNC +: W_DATA];
            d_trans_cnt = TCNT_HALF0;
            d_valid     = 1'b1;
            d_tcnt      = TCNT_HALF1;
         end
         ActHalf1: begin
            consumed    = FILL_WORD;
            d_rx        = q_buf[W_DATA-1:0];
            d_trans_cnt = TCNT_HALF1;
            d_valid     = 1'b1;
            d_tcnt      = TCNT_HALF0;
         end
         ActIdle: begin
         end
      endcase

      // A request arriving while one is already pending merges into it.
      if (action == ActSlip) begin
         d_slip_pend = 1'b0;
      end else if (i_slip) begin
         d_slip_pend = 1'b1;
      end else begin
         d_slip_pend = q_slip_pend;
      end
   end

   // Consume from the bottom, then append the new word just above what remains.
   // Bits above the fill level are always zero, so OR-ing the word in is safe.
   always_comb begin
      insert_pos = q_fill - consumed;
      d_buf      = (q_buf >> consumed)
                 | (W_RX_GEARBOX_BUF'(i_pma_data) << insert_pos);
      d_fill     = insert_pos + FILL_WORD;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         q_buf       <= '0;
         q_fill      <= '0;
         q_tcnt      <= '0;
         q_slip_pend <= 1'b0;
         o_valid     <= 1'b0;
         o_slip_done <= 1'b0;
         o_sync_data <= '0;
         o_rx_data   <= '0;
         o_trans_cnt <= '0;
      end else begin
         q_buf       <= d_buf;
         q_fill      <= d_fill;
         q_tcnt      <= d_tcnt;
         q_slip_pend <= d_slip_pend;
         o_valid     <= d_valid;
         o_slip_done <= d_slip_done;
         o_sync_data <= d_sync;
         o_rx_data   <= d_rx;
         o_trans_cnt <= d_trans_cnt;
      end
   end

endmodule

// File: tb/tb_eth_pcs_rx_gearbox.sv
// -----------------------------------------------------------------------------
// tb_eth_pcs_rx_gearbox
// Directed bench for the receive gearbox. A table of eight hand-chosen blocks
// is serialised bit by bit (header bit 0 first, then half 0, then half 1) into
// a PMA word stream, optionally preceded by one extra bit. Every valid output
// is compared against the table entry it must come from.
// -----------------------------------------------------------------------------
module tb_eth_pcs_rx_gearbox;
   import eth_pcs_pkg::*;

   localparam int NBLK = 240;

   logic                       clk;
   logic                       reset;
   logic [W_DATA-1:0]          pma_data;
   logic                       slip;
   logic                       valid;
   logic [W_SYNC-1:0]          sync_data;
   logic [W_DATA-1:0]          rx_data;
   logic [W_TRANS_PER_BLK-1:0] trans_cnt;
   logic                       slip_done;

   eth_pcs_rx_gearbox dut (
      .i_clk       (clk),
      .i_reset     (reset),
      .i_pma_data  (pma_data),
      .i_slip      (slip),
      .o_valid     (valid),
      .o_sync_data (sync_data),
      .o_rx_data   (rx_data),
      .o_trans_cnt (trans_cnt),
      .o_slip_done (slip_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]  tbl_hdr [8];
   logic [31:0] tbl_d0  [8];
   logic [31:0] tbl_d1  [8];

   bit          bits  [$];
   logic [31:0] words [$];

   int n_checks = 0;
   int n_errors = 0;
   int widx;
   int n_valid;
   int n_slip;
   int hdr_seen;
   int exp_blk;
   int exp_half;
   bit chk_en;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic build_stream(input int offset);
      bits.delete();
      words.delete();
      for (int i = 0; i < offset; i++) bits.push_back(1'b0);
      for (int b = 0; b < NBLK; b++) begin
         for (int i = 0; i < 2; i++)  bits.push_back(tbl_hdr[b % 8][i]);
         for (int i = 0; i < 32; i++) bits.push_back(tbl_d0[b % 8][i]);
         for (int i = 0; i < 32; i++) bits.push_back(tbl_d1[b % 8][i]);
      end
      for (int k = 0; (k + 1) * 32 <= bits.size(); k++) begin
         logic [31:0] w;
         for (int i = 0; i < 32; i++) w[i] = bits[k * 32 + i];
         words.push_back(w);
      end
   endtask

   // One clock: sample outputs 1 time unit after the edge, score any valid
   // transfer, then present the next word and drop any slip pulse.
   task automatic tick();
      @(posedge clk);
      #1;
      if (valid) begin
         n_valid++;
         if (chk_en) begin
            check("trans_cnt", 64'(trans_cnt), 64'(exp_half));
            if (exp_half == 0) begin
               check("sync", 64'(sync_data), 64'(tbl_hdr[exp_blk % 8]));
               check("half0", 64'(rx_data), 64'(tbl_d0[exp_blk % 8]));
               exp_half = 1;
            end else begin
               check("half1", 64'(rx_data), 64'(tbl_d1[exp_blk % 8]));
               exp_half = 0;
               exp_blk++;
            end
         end else if (trans_cnt == 1'b0) begin
            hdr_seen++;
         end
      end
      if (slip_done) n_slip++;
      pma_data = (widx < words.size()) ? words[widx] : 32'h0;
      widx++;
      slip = 1'b0;
   endtask

   task automatic restart_stream();
      widx     = 0;
      pma_data = words[0];
      widx     = 1;
      n_valid  = 0;
      n_slip   = 0;
      hdr_seen = 0;
      exp_blk  = 0;
      exp_half = 0;
   endtask

   task automatic start(input int offset);
      build_stream(offset);
      slip  = 1'b0;
      reset = 1'b1;
      widx  = 0;
      tick();
      tick();
      reset = 1'b0;
      restart_stream();
      chk_en = (offset == 0);
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_valid"}, 64'(valid), 64'h0);
      check({tag, "_done"},  64'(slip_done), 64'h0);
      check({tag, "_sync"},  64'(sync_data), 64'h0);
      check({tag, "_rx"},    64'(rx_data), 64'h0);
      check({tag, "_tcnt"},  64'(trans_cnt), 64'h0);
   endtask

   // Run until the second header of the misaligned stream has been emitted,
   // leaving the gearbox inside a block (half 1 still to come).
   task automatic wait_second_header();
      bit found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         tick();
         if (valid && trans_cnt == 1'b0 && hdr_seen >= 2) found = 1'b1;
      end
      check("hdr_found", 64'(found), 64'h1);
   endtask

   task automatic realign_model();
      chk_en   = 1'b1;
      exp_blk  = hdr_seen;
      exp_half = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit got;
      int waited;

      tbl_hdr[0] = SYNC_DATA; tbl_d0[0] = 32'h0000_0000; tbl_d1[0] = 32'h0000_0000;
      tbl_hdr[1] = SYNC_CTRL; tbl_d0[1] = 32'hDEAD_BEEF; tbl_d1[1] = 32'h1234_5678;
      tbl_hdr[2] = SYNC_DATA; tbl_d0[2] = 32'hFFFF_FFFF; tbl_d1[2] = 32'h0000_0000;
      tbl_hdr[3] = SYNC_CTRL; tbl_d0[3] = 32'hA5A5_A5A5; tbl_d1[3] = 32'h5A5A_5A5A;
      tbl_hdr[4] = SYNC_DATA; tbl_d0[4] = 32'h0000_0001; tbl_d1[4] = 32'h8000_0000;
      tbl_hdr[5] = SYNC_CTRL; tbl_d0[5] = 32'hCAFE_F00D; tbl_d1[5] = 32'h0BAD_C0DE;
      tbl_hdr[6] = SYNC_DATA; tbl_d0[6] = 32'h1357_9BDF; tbl_d1[6] = 32'h2468_ACE0;
      tbl_hdr[7] = SYNC_CTRL; tbl_d0[7] = 32'hFFFF_FFFF; tbl_d1[7] = 32'hFFFF_FFFF;
      chk_en = 1'b0;
      slip   = 1'b0;
      pma_data = '0;

      // Aligned stream: reset state, first-transfer latency, then throughput.
      start(0);
      check_zero_outputs("rst");
      check("word0", 64'(words[0]), 64'h1);
      tick();
      check("lat_e1", 64'(valid), 64'h0);
      tick();
      check("lat_e2", 64'(valid), 64'h0);
      tick();
      check("lat_e3", 64'(valid), 64'h1);
      check("first_sync", 64'(sync_data), 64'(SYNC_DATA));
      check("first_tcnt", 64'(trans_cnt), 64'h0);
      tick();
      check("second_tcnt", 64'(trans_cnt), 64'h1);
      repeat (8) tick();
      n_valid = 0;
      repeat (330) tick();
      check("valid_330", 64'(n_valid), 64'd320);
      check("no_slip_aligned", 64'(n_slip), 64'h0);

      // One-bit offset, single slip requested mid-block.
      start(1);
      wait_second_header();
      slip = 1'b1;
      tick();
      check("slip_not_early", 64'(slip_done), 64'h0);
      got    = 1'b0;
      waited = 0;
      for (int i = 0; i < 4 && !got; i++) begin
         tick();
         waited++;
         if (slip_done) begin
            got = 1'b1;
            check("slip_valid", 64'(valid), 64'h0);
            realign_model();
         end
      end
      check("slip_seen", 64'(got), 64'h1);
      check("slip_lat", 64'(waited), 64'h1);
      n_valid = 0;
      repeat (60) tick();
      check("slip_count", 64'(n_slip), 64'h1);
      check("post_slip_flow", 64'(n_valid >= 56), 64'h1);

      // One-bit offset, slip held high for two cycles: only one bit dropped.
      start(1);
      wait_second_header();
      slip = 1'b1;
      tick();
      check("dbl_not_early", 64'(slip_done), 64'h0);
      slip = 1'b1;
      tick();
      check("dbl_done", 64'(slip_done), 64'h1);
      check("dbl_valid", 64'(valid), 64'h0);
      realign_model();
      repeat (60) tick();
      check("dbl_count", 64'(n_slip), 64'h1);

      // Reset mid-block with a slip pending.
      start(0);
      tick();
      tick();
      tick();
      check("rp_hdr", 64'(valid && trans_cnt == 1'b0), 64'h1);
      slip = 1'b1;
      tick();
      reset = 1'b1;
      tick();
      check_zero_outputs("midrst");
      reset = 1'b0;
      restart_stream();
      chk_en = 1'b1;
      tick();
      check("rp_e1", 64'(valid), 64'h0);
      tick();
      check("rp_e2", 64'(valid), 64'h0);
      tick();
      check("rp_e3", 64'(valid), 64'h1);
      repeat (10) tick();
      check("rp_no_slip", 64'(n_slip), 64'h0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/eth_pcs_rx_gearbox.md
Name: eth_pcs_rx_gearbox

Overview:
Receive-side 32-to-66 gearbox of the 10GBASE-R PCS. It sits between the PMA deserializer and the descrambler/block-lock logic. It accepts one 32-bit PMA word every cycle and reassembles 66-bit blocks, emitted as a 2-bit sync header plus two 32-bit halves. It supports a single-bit slip, requested by the block-lock FSM, to realign block boundaries.

Parameters:
W_DATA, 32, PMA word width and width of each emitted data half (shared package constant)
W_SYNC, 2, sync header width (package)
W_TRANS_PER_BLK, 1, width of the transfer counter; 2 transfers per 64-bit payload (package)
W_RX_GEARBOX_BUF, 98, buffer width = W_SYNC + 3*W_DATA (package)
W_RX_GEARBOX_FILL, 7, width of the fill counter; holds 0..97 (package)

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous, active-high reset
i_pma_data  in  W_DATA  PMA word; bit 0 is the earliest received bit; valid every cycle
i_slip  in  1  single-cycle request to discard one bit at the next block boundary
o_valid  out  1  o_rx_data and o_sync_data carry a transfer this cycle
o_sync_data  out  W_SYNC  block sync header; meaningful only when o_valid=1 and o_trans_cnt=0
o_rx_data  out  W_DATA  payload half; half 0 (bits 31:0) first, then half 1
o_trans_cnt  out  W_TRANS_PER_BLK  payload half index of the current output
o_slip_done  out  1  one-cycle pulse in the cycle the slip is executed

Behaviour:
- State: q_buf (bit 0 = oldest bit), q_fill (number of valid bits), q_tcnt (next half index), q_slip_pend, plus registered outputs.
- Each edge, the extraction decision uses only the pre-append q_buf/q_fill. The new word is appended at bit q_fill after any consumption: d_buf = (q_buf >> consumed) with i_pma_data at [q_fill-consumed +: 32], and d_fill = q_fill - consumed + 32.
- Slip at boundary: if q_tcnt=0 and slip is pending (q_slip_pend, or i_slip in this cycle) and q_fill>=1:
  - consumed = 1; o_valid<=0; o_slip_done<=1; pending cleared; q_tcnt stays 0.
  - Slip has priority over emission.
- Header + half 0: else if q_tcnt=0 and q_fill>=34:
  - o_sync_data<=q_buf[1:0]; o_rx_data<=q_buf[33:2]; o_trans_cnt<=0; o_valid<=1.
  - consumed = 34; q_tcnt<=1.
- Half 1: else if q_tcnt=1 and q_fill>=32:
  - o_rx_data<=q_buf[31:0]; o_trans_cnt<=1; o_valid<=1 (o_sync_data holds its previous value).
  - consumed = 32; q_tcnt<=0.
- Otherwise: consumed = 0; o_valid<=0; other outputs hold.
- Slip deferral: i_slip while q_tcnt=1 sets q_slip_pend; the slip executes at the next q_tcnt=0 cycle. i_slip while a slip is already pending is ignored; at most one slip is outstanding.
- Throughput: with no slips, exactly 32 valid transfers per 33 cycles; the single o_valid=0 cycle falls where fill is short. q_fill never exceeds 97, so no overflow is possible. Each slip adds one extra invalid cycle.
- Latency: after reset deassertion, words land on edges 1 and 2; the first o_valid=1 follows edge 3. In steady state, a bit is output 2–3 cycles after entry.
- Reset (any time, including mid-block or with a slip pending): q_buf=0, q_fill=0, q_tcnt=0, q_slip_pend=0, o_valid=0, o_slip_done=0, o_sync_data=0, o_rx_data=0, o_trans_cnt=0. The word presented during reset is discarded.
- No check of header validity here; the block-lock FSM downstream evaluates o_sync_data.

Decomposition:
- Package eth_pcs_pkg holds W_DATA, W_SYNC, W_TRANS_PER_BLK, W_RX_GEARBOX_BUF, W_RX_GEARBOX_FILL, and SYNC_DATA=2'b01 / SYNC_CTRL=2'b10 for benches and the lock FSM.
- Single module; no sub-module is warranted (shift/insert logic is one always_comb, state is one always_ff).

Test Plan:
- Reset then words 32'h0000_0001, 32'h0000_0000 repeated -> first o_valid after edge 3 with o_sync_data=2'b01, o_rx_data=0, o_trans_cnt=0; next cycle o_trans_cnt=1, o_rx_data=0; headers stay 2'b01 for all blocks.
- Loopback from eth_pcs_tx_gearbox with random 64-bit payloads and alternating 2'b01/2'b10 headers -> bit-exact block sequence recovered once aligned.
- Aligned stream, run 330 cycles -> exactly 320 o_valid cycles, o_trans_cnt strictly alternating 0,1.
- Stream offset by 1 bit (prepend one bit), pulse i_slip during a q_tcnt=1 cycle -> o_slip_done one cycle later at the boundary, o_valid=0 that cycle; subsequent headers all correct.
- i_slip on two consecutive cycles -> only one o_slip_done, fill decremented by 1 only.
- Assert i_reset mid-block with a pending slip -> all outputs 0 next cycle, no o_slip_done after release, first o_valid after edge 3 again.
